// File: rtl/mux_demux_4ch_pkg.sv
// Shared definitions for the 4-lane mux/demux link.
// Holds the data width default, lane count, selector width, the lane select
// encodings and a helper that decodes a lane select into a one-hot lane mask.
package mux_demux_4ch_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int NUM_LANES  = 4;
  localparam int SEL_WIDTH  = 2;

  localparam logic [SEL_WIDTH-1:0] LANE0 = 2'd0;
  localparam logic [SEL_WIDTH-1:0] LANE1 = 2'd1;
  localparam logic [SEL_WIDTH-1:0] LANE2 = 2'd2;
  localparam logic [SEL_WIDTH-1:0] LANE3 = 2'd3;

  // One-hot decode of a lane select; unknown selects fall back to lane 0.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_WIDTH-1:0] sel);
    logic [NUM_LANES-1:0] mask;
    case (sel)
      LANE0:   mask = 4'b0001;
      LANE1:   mask = 4'b0010;
      LANE2:   mask = 4'b0100;
      LANE3:   mask = 4'b1000;
      default: mask = 4'b0001;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mux_demux_4ch_if.sv
// Bus bundle for mux_demux_4ch.
// master: drives enable, the four mux lanes and both selectors; observes the
//         shared channel and the four demux lanes.
// slave : the design side (inputs and outputs reversed).
interface mux_demux_4ch_if
  import mux_demux_4ch_pkg::*;
#(
  parameter int DATA_WIDTH = mux_demux_4ch_pkg::DATA_WIDTH
) ();

  logic                  enb;
  logic [DATA_WIDTH-1:0] entrada0_mux;
  logic [DATA_WIDTH-1:0] entrada1_mux;
  logic [DATA_WIDTH-1:0] entrada2_mux;
  logic [DATA_WIDTH-1:0] entrada3_mux;
  logic [SEL_WIDTH-1:0]  selector_mux;
  logic [SEL_WIDTH-1:0]  selector_dmux;
  logic [DATA_WIDTH-1:0] salida_mux;
  logic [DATA_WIDTH-1:0] salida0_dmux;
  logic [DATA_WIDTH-1:0] salida1_dmux;
  logic [DATA_WIDTH-1:0] salida2_dmux;
  logic [DATA_WIDTH-1:0] salida3_dmux;

  modport master (
    output enb, entrada0_mux, entrada1_mux, entrada2_mux, entrada3_mux,
    output selector_mux, selector_dmux,
    input  salida_mux, salida0_dmux, salida1_dmux, salida2_dmux, salida3_dmux
  );

  modport slave (
    input  enb, entrada0_mux, entrada1_mux, entrada2_mux, entrada3_mux,
    input  selector_mux, selector_dmux,
    output salida_mux, salida0_dmux, salida1_dmux, salida2_dmux, salida3_dmux
  );

endinterface

// File: rtl/mux_demux_4ch_lane_demux4.sv
// Registered 1-to-4 lane demultiplexer.
// Ports: clk, reset_L (async active-low), enb (0 clears all lanes), din word
//        from the shared channel, sel output lane select, out0..out3 registered
//        lanes (only the selected one carries din, the rest are zero).
module mux_demux_4ch_lane_demux4
  import mux_demux_4ch_pkg::*;
#(
  parameter int DATA_WIDTH = mux_demux_4ch_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enb,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3
);

  logic [NUM_LANES-1:0]                 lane_mask;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_next;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_q;

  // Route din to the selected lane only; every other lane loads zero.
  always_comb begin
    lane_mask = lane_onehot(sel);
    for (int i = 0; i < NUM_LANES; i++) begin
      if (enb && lane_mask[i]) begin
        lane_next[i] = din;
      end else begin
        lane_next[i] = {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Output lane registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      lane_q <= lane_next;
    end
  end

  assign out0 = lane_q[0];
  assign out1 = lane_q[1];
  assign out2 = lane_q[2];
  assign out3 = lane_q[3];

endmodule

// File: rtl/mux_demux_4ch_lane_mux4.sv
// Registered 4-to-1 lane multiplexer.
// Ports: clk, reset_L (async active-low), enb (0 loads zero), in0..in3 lanes,
//        sel lane select, out registered selected lane.
module mux_demux_4ch_lane_mux4
  import mux_demux_4ch_pkg::*;
#(
  parameter int DATA_WIDTH = mux_demux_4ch_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enb,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] out
);

  logic [DATA_WIDTH-1:0] out_next;

  // Select the lane to load next; a disabled stage loads zero.
  always_comb begin
    out_next = {DATA_WIDTH{1'b0}};
    if (enb) begin
      case (sel)
        LANE0:   out_next = in0;
        LANE1:   out_next = in1;
        LANE2:   out_next = in2;
        LANE3:   out_next = in3;
        default: out_next = in0;
      endcase
    end else begin
      out_next = {DATA_WIDTH{1'b0}};
    end
  end

  // Shared channel register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      out <= {DATA_WIDTH{1'b0}};
    end else begin
      out <= out_next;
    end
  end

endmodule

// File: rtl/mux_demux_4ch.sv
// 4-lane link: registered 4-to-1 mux onto a shared channel followed by a
// registered 1-to-4 demux back out to one of four lanes.
// Ports: clk, reset_L (async active-low), bus (slave side of
//        mux_demux_4ch_if: enable, lanes, selectors in; channel and demux
//        lanes out). The demux select is not pipelined: it steers whatever
//        word is currently held on the channel.
module mux_demux_4ch
  import mux_demux_4ch_pkg::*;
#(
  parameter int DATA_WIDTH = mux_demux_4ch_pkg::DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_L,
  mux_demux_4ch_if.slave       bus
);

  logic [DATA_WIDTH-1:0] channel;

  mux_demux_4ch_lane_mux4 #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
    .clk     (clk),
    .reset_L (reset_L),
    .enb     (bus.enb),
    .in0     (bus.entrada0_mux),
    .in1     (bus.entrada1_mux),
    .in2     (bus.entrada2_mux),
    .in3     (bus.entrada3_mux),
    .sel     (bus.selector_mux),
    .out     (channel)
  );

  mux_demux_4ch_lane_demux4 #(.DATA_WIDTH(DATA_WIDTH)) u_demux (
    .clk     (clk),
    .reset_L (reset_L),
    .enb     (bus.enb),
    .din     (channel),
    .sel     (bus.selector_dmux),
    .out0    (bus.salida0_dmux),
    .out1    (bus.salida1_dmux),
    .out2    (bus.salida2_dmux),
    .out3    (bus.salida3_dmux)
  );

  assign bus.salida_mux = channel;

endmodule

// File: tb/tb_mux_demux_4ch.sv
// Directed self-checking bench for mux_demux_4ch.
module tb_mux_demux_4ch;
  import mux_demux_4ch_pkg::*;

  logic clk;
  logic reset_L;
  int   n_checks;
  int   n_errors;

  mux_demux_4ch_if #(.DATA_WIDTH(4)) bus ();

  mux_demux_4ch #(.DATA_WIDTH(4)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any mismatch.
  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dmux_all();
    return {bus.salida3_dmux, bus.salida2_dmux, bus.salida1_dmux, bus.salida0_dmux};
  endfunction

  task automatic check_out(input string tag, input logic [3:0] exp_mux, input logic [15:0] exp_dmux);
    check_val({tag, "_mux"}, {12'h000, bus.salida_mux}, {12'h000, exp_mux});
    check_val({tag, "_dmux"}, dmux_all(), exp_dmux);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Test 1: asynchronous reset with all lanes high.
    reset_L           = 1'b1;
    bus.enb           = 1'b1;
    bus.entrada0_mux  = 4'b1111;
    bus.entrada1_mux  = 4'b1111;
    bus.entrada2_mux  = 4'b1111;
    bus.entrada3_mux  = 4'b1111;
    bus.selector_mux  = 2'b00;
    bus.selector_dmux = 2'b00;
    tick();
    check_val("pre_reset_mux", {12'h000, bus.salida_mux}, 16'h000F);
    #2;
    reset_L = 1'b0;
    #1;
    check_out("reset_async", 4'b0000, 16'h0000);
    tick();
    check_out("reset_hold", 4'b0000, 16'h0000);
    reset_L = 1'b1;
    tick();
    check_out("reset_release", 4'b1111, 16'h0000);

    // Test 2: enable low forces zeros.
    bus.enb           = 1'b0;
    bus.entrada0_mux  = 4'b0010;
    bus.entrada1_mux  = 4'b1010;
    bus.entrada2_mux  = 4'b0110;
    bus.entrada3_mux  = 4'b1011;
    bus.selector_mux  = 2'b00;
    bus.selector_dmux = 2'b10;
    tick();
    tick();
    check_out("enb_low", 4'b0000, 16'h0000);

    // Tests 3/4: mux sweep with demux selects skewed one cycle behind.
    bus.enb           = 1'b1;
    bus.entrada0_mux  = 4'b1110;
    bus.entrada1_mux  = 4'b1110;
    bus.entrada2_mux  = 4'b1100;
    bus.entrada3_mux  = 4'b1000;
    bus.selector_mux  = 2'b00;
    bus.selector_dmux = 2'b00;
    tick();
    check_out("sweep_sel0", 4'b1110, 16'h0000);
    bus.selector_mux  = 2'b01;
    bus.selector_dmux = 2'b11;
    tick();
    check_out("sweep_sel1", 4'b1110, 16'hE000);
    bus.selector_mux  = 2'b10;
    bus.selector_dmux = 2'b10;
    tick();
    check_out("sweep_sel2", 4'b1100, 16'h0E00);
    bus.selector_mux  = 2'b11;
    bus.selector_dmux = 2'b01;
    tick();
    check_out("sweep_sel3", 4'b1000, 16'h00C0);
    bus.selector_mux  = 2'b00;
    bus.selector_dmux = 2'b00;
    tick();
    check_out("route_lane0", 4'b1110, 16'h0008);

    // Test 5: enable drop while the channel holds 1100, then recovery.
    bus.selector_mux = 2'b10;
    tick();
    check_out("pre_drop", 4'b1100, 16'h000E);
    bus.enb = 1'b0;
    tick();
    check_out("enb_drop", 4'b0000, 16'h0000);
    bus.enb           = 1'b1;
    bus.selector_mux  = 2'b11;
    bus.selector_dmux = 2'b00;
    tick();
    check_out("reenb_edge1", 4'b1000, 16'h0000);
    tick();
    check_out("reenb_edge2", 4'b1000, 16'h0008);

    // Test 6: reset pulse between edges mid-stream.
    bus.selector_mux = 2'b00;
    tick();
    check_out("stream_pre", 4'b1110, 16'h0008);
    bus.selector_mux = 2'b01;
    #2;
    reset_L = 1'b0;
    #1;
    check_out("midstream_reset", 4'b0000, 16'h0000);
    reset_L = 1'b1;
    tick();
    check_out("refill_edge1", 4'b1110, 16'h0000);
    bus.selector_dmux = 2'b10;
    tick();
    check_out("refill_edge2", 4'b1110, 16'h0E00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
